fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_pc_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and
// instruction/PC constants.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

  localparam int unsigned InstrWidth = 16;
  localparam logic [15:0] PcInc      = 16'd2;
  localparam logic [InstrWidth-1:0] BubbleWord = 16'h0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection: hold, +2 advance, or
// redirect load. The PC is kept halfword aligned at all times.
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  input  logic        load,
  input  logic [14:0] load_pc_hi,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2
);

  logic [15:0] pc_d;
  logic [15:0] pc_q;

  // Wraps modulo 2^16 with no carry out.
  assign pc_plus2 = pc_q + PcInc;
  assign pc       = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = {load_pc_hi, 1'b0};
    end else if (advance) begin
      pc_d = pc_plus2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= {RESET_PC[15:1], 1'b0};
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: boot/run/halt sequencing, IF/ID pipeline register
// and a saturating count of delivered instructions.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [15:0]           iaddr,
  input  logic [InstrWidth-1:0] idata,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [15:0]           redirect_pc,
  input  logic                  halt,
  input  logic                  resume,
  output logic [InstrWidth-1:0] ifid_instr,
  output logic [15:0]           ifid_pc2,
  output logic                  ifid_valid,
  output logic                  halted,
  output logic [15:0]           fetch_count
);

  localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

  fetch_state_e          state_q;
  logic [3:0]            boot_cnt_q;
  logic [InstrWidth-1:0] instr_q;
  logic [15:0]           pc2_q;
  logic                  valid_q;
  logic                  halted_q;
  logic [15:0]           count_q;

  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        in_run;
  logic        in_halted;
  logic        take_redirect;
  logic        take_halt;
  logic        take_fetch;

  // Redirect outranks halt, which outranks stall; BOOT ignores all of them.
  always_comb begin
    in_run        = (state_q == StRun);
    in_halted     = (state_q == StHalted);
    take_redirect = redirect & (in_run | in_halted);
    take_halt     = in_run & halt & ~redirect;
    take_fetch    = in_run & ~redirect & ~halt & ~stall;
  end

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock      (clock),
    .reset      (reset),
    .advance    (take_fetch),
    .load       (take_redirect),
    .load_pc_hi (redirect_pc[15:1]),
    .pc         (pc),
    .pc_plus2   (pc_plus2)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StBoot;
      boot_cnt_q <= 4'd0;
      instr_q    <= BubbleWord;
      pc2_q      <= 16'h0000;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      case (state_q)
        StBoot: begin
          if (boot_cnt_q == BootLast) begin
            state_q <= StRun;
          end else begin
            boot_cnt_q <= boot_cnt_q + 4'd1;
          end
        end
        StRun: begin
          if (take_redirect) begin
            // Flush the wrong-path word even if decode is stalling.
            valid_q <= 1'b0;
            instr_q <= BubbleWord;
          end else if (take_halt) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
            valid_q  <= 1'b0;
          end else if (take_fetch) begin
            instr_q <= idata;
            pc2_q   <= pc_plus2;
            valid_q <= 1'b1;
            if (count_q != 16'hFFFF) begin
              count_q <= count_q + 16'd1;
            end
          end
        end
        StHalted: begin
          if (take_redirect) begin
            instr_q <= BubbleWord;
          end
          if (resume) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StBoot;
          halted_q <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign iaddr       = pc;
  assign ifid_instr  = instr_q;
  assign ifid_pc2    = pc2_q;
  assign ifid_valid  = valid_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule
